// File: rtl/ov2640_capture_if.sv
// ov2640_capture_if: DVP camera inputs and the RGB565 pixel write bus.
// The capture block connects through the slave modport; the camera side
// (or a bench) drives it through the master modport.
interface ov2640_capture_if #(
    parameter int ADDR_W = 17
) ();
    logic              capture_en;
    logic              cam_vsync;
    logic              cam_href;
    logic [7:0]        cam_data;
    logic [15:0]       pixel_out;
    logic              pixel_valid;
    logic [ADDR_W-1:0] wr_addr;
    logic              frame_done;
    logic              busy;

    modport master (
        output capture_en, cam_vsync, cam_href, cam_data,
        input  pixel_out, pixel_valid, wr_addr, frame_done, busy
    );

    modport slave (
        input  capture_en, cam_vsync, cam_href, cam_data,
        output pixel_out, pixel_valid, wr_addr, frame_done, busy
    );
endinterface

// File: rtl/ov2640_capture.sv
// ov2640_capture: OV2640 DVP byte stream (VSYNC/HREF/D[7:0]) to RGB565 pixels
// with a linear frame-buffer write address. Whole frames only; a frame is
// armed at the VSYNC falling edge when capture_en is high.
// Optional build macro OV2640_CAPTURE_STATS_EN adds frame_cnt and a sticky
// line_err output.
module ov2640_capture #(
    parameter int H_RES  = 320,
    parameter int V_RES  = 240,
    parameter int ADDR_W = 17
) (
    input  logic              clk_in,
    input  logic              rst,
    ov2640_capture_if.slave   bus
`ifdef OV2640_CAPTURE_STATS_EN
    ,
    output logic [15:0]       frame_cnt,
    output logic [0:0]        line_err
`endif
);

    // The address counter is one bit wider than wr_addr so it can hold
    // H_RES*V_RES itself, which is the overflow (stop) value.
    localparam int unsigned  TOTAL     = H_RES * V_RES;
    localparam logic [ADDR_W:0] TOTAL_CNT = (ADDR_W + 1)'(TOTAL);
    localparam logic [ADDR_W:0] ADDR_ONE  = (ADDR_W + 1)'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              vsync_q, vsync_d;
    logic              href_q, href_d;
    logic              phase_q, phase_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [ADDR_W:0]   addr_cnt_q, addr_cnt_d;
    logic [15:0]       pixel_out_q, pixel_out_d;
    logic              pixel_valid_q, pixel_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_done_q, frame_done_d;

    logic              vs_fall;
    logic              vs_rise;
    logic              hr_fall;
    logic              arm;

    assign vs_fall = vsync_q & ~bus.cam_vsync;
    assign vs_rise = ~vsync_q & bus.cam_vsync;
    assign hr_fall = href_q & ~bus.cam_href;
    assign arm     = (state_q == ST_WAIT) && vs_fall && bus.capture_en;

    // Frame FSM, byte pairing and pixel/address output staging.
    always_comb begin
        state_d       = state_q;
        vsync_d       = bus.cam_vsync;
        href_d        = bus.cam_href;
        phase_d       = phase_q;
        hi_byte_d     = hi_byte_q;
        addr_cnt_d    = addr_cnt_q;
        pixel_out_d   = pixel_out_q;
        pixel_valid_d = 1'b0;
        wr_addr_d     = wr_addr_q;
        frame_done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_WAIT;
            end

            ST_WAIT: begin
                if (arm) begin
                    state_d    = ST_CAPTURE;
                    addr_cnt_d = '0;
                    phase_d    = 1'b0;
                end
            end

            ST_CAPTURE: begin
                if (bus.cam_href) begin
                    if (!phase_q) begin
                        hi_byte_d = bus.cam_data;
                        phase_d   = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // Past the last frame address the pixel is dropped
                        // and the counter holds instead of wrapping.
                        if (addr_cnt_q < TOTAL_CNT) begin
                            pixel_out_d   = {hi_byte_q, bus.cam_data};
                            wr_addr_d     = addr_cnt_q[ADDR_W-1:0];
                            pixel_valid_d = 1'b1;
                            addr_cnt_d    = addr_cnt_q + ADDR_ONE;
                        end
                    end
                end else if (hr_fall) begin
                    // An odd trailing byte is discarded here.
                    phase_d = 1'b0;
                end

                // A pixel completing on the same edge is still emitted above.
                if (vs_rise) begin
                    state_d      = ST_WAIT;
                    frame_done_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            vsync_q       <= 1'b0;
            href_q        <= 1'b0;
            phase_q       <= 1'b0;
            hi_byte_q     <= '0;
            addr_cnt_q    <= '0;
            pixel_out_q   <= '0;
            pixel_valid_q <= 1'b0;
            wr_addr_q     <= '0;
            frame_done_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            vsync_q       <= vsync_d;
            href_q        <= href_d;
            phase_q       <= phase_d;
            hi_byte_q     <= hi_byte_d;
            addr_cnt_q    <= addr_cnt_d;
            pixel_out_q   <= pixel_out_d;
            pixel_valid_q <= pixel_valid_d;
            wr_addr_q     <= wr_addr_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign bus.pixel_out   = pixel_out_q;
    assign bus.pixel_valid = pixel_valid_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.busy        = (state_q == ST_CAPTURE);

`ifdef OV2640_CAPTURE_STATS_EN
    // Per-line pixel count saturates one above H_RES so long lines still
    // compare unequal.
    localparam int              LPX_W   = $clog2(H_RES + 2);
    localparam logic [LPX_W-1:0] LPX_H   = LPX_W'(H_RES);
    localparam logic [LPX_W-1:0] LPX_MAX = LPX_W'(H_RES + 1);
    localparam logic [LPX_W-1:0] LPX_ONE = LPX_W'(1);

    logic [15:0]      frame_cnt_q, frame_cnt_d;
    logic             line_err_q, line_err_d;
    logic [LPX_W-1:0] line_px_q, line_px_d;

    // Frame counter and sticky line-length / odd-byte error tracking.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        line_err_d  = line_err_q;
        line_px_d   = line_px_q;

        if (frame_done_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (arm) begin
            line_px_d = '0;
        end else if (state_q == ST_CAPTURE) begin
            if (hr_fall) begin
                if ((line_px_q != LPX_H) || phase_q) begin
                    line_err_d = 1'b1;
                end
                line_px_d = '0;
            end else if (pixel_valid_d && (line_px_q != LPX_MAX)) begin
                line_px_d = line_px_q + LPX_ONE;
            end
        end
    end

    // Statistics registers, cleared only by reset.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            frame_cnt_q <= '0;
            line_err_q  <= 1'b0;
            line_px_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            line_err_q  <= line_err_d;
            line_px_q   <= line_px_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign line_err  = line_err_q;
`endif

endmodule

// File: tb/tb_ov2640_capture.sv
// tb_ov2640_capture: scoreboard bench for ov2640_capture at H_RES=4, V_RES=2.
// Stimulus tasks drive DVP bytes and push expected pixels / frame_done pulses
// (with the cycle they must appear in); a monitor pops and compares them.
module tb_ov2640_capture;
    localparam int H   = 4;
    localparam int V   = 2;
    localparam int AW  = 3;
    localparam int TOT = H * V;

    typedef struct {
        logic [15:0]   data;
        logic [AW-1:0] addr;
        int            stamp;
    } pix_t;

    logic clk_in = 1'b0;
    logic rst    = 1'b1;
    always #5 clk_in = ~clk_in;

    ov2640_capture_if #(.ADDR_W(AW)) bus ();

`ifdef OV2640_CAPTURE_STATS_EN
    logic [15:0] frame_cnt;
    logic [0:0]  line_err;
`endif

    ov2640_capture #(.H_RES(H), .V_RES(V), .ADDR_W(AW)) dut (
        .clk_in (clk_in),
        .rst    (rst),
        .bus    (bus)
`ifdef OV2640_CAPTURE_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .line_err  (line_err)
`endif
    );

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    pix_t pix_q[$];
    int   fd_q[$];
    pix_t mon_e;
    int   mon_f;
    bit   expect_idle = 1'b0;

    // Reference model state: frame armed, next address, frames done, sticky error.
    bit   m_armed = 1'b0;
    int   m_addr  = 0;
    int   m_frames = 0;
    bit   m_err   = 1'b0;

    logic [7:0] line_b[$];

    always @(posedge clk_in) cyc <= cyc + 1;

    // Monitor: match every strobe against the scoreboard, flag overdue entries.
    always @(negedge clk_in) begin
        if (bus.pixel_valid === 1'b1) begin
            checks++;
            if (pix_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pixel got %h addr %0d cyc %0d want none",
                         bus.pixel_out, bus.wr_addr, cyc);
            end else begin
                mon_e = pix_q.pop_front();
                if (bus.pixel_out !== mon_e.data || bus.wr_addr !== mon_e.addr || cyc != mon_e.stamp) begin
                    errors++;
                    $display("FAIL pixel got %h addr %0d cyc %0d want %h addr %0d cyc %0d",
                             bus.pixel_out, bus.wr_addr, cyc, mon_e.data, mon_e.addr, mon_e.stamp);
                end
            end
        end
        while (pix_q.size() > 0 && pix_q[0].stamp < cyc) begin
            mon_e = pix_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_pixel got none want %h addr %0d cyc %0d", mon_e.data, mon_e.addr, mon_e.stamp);
        end
        if (bus.frame_done === 1'b1) begin
            checks++;
            if (fd_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_frame_done got 1 at cyc %0d want 0", cyc);
            end else begin
                mon_f = fd_q.pop_front();
                if (cyc != mon_f) begin
                    errors++;
                    $display("FAIL frame_done_cycle got %0d want %0d", cyc, mon_f);
                end
            end
        end
        while (fd_q.size() > 0 && fd_q[0] < cyc) begin
            mon_f = fd_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_frame_done got none want cyc %0d", mon_f);
        end
        if (expect_idle) begin
            checks++;
            if (bus.busy !== 1'b0 || bus.pixel_valid !== 1'b0 || bus.frame_done !== 1'b0) begin
                errors++;
                $display("FAIL disarmed_idle got busy %b valid %b done %b want 0 0 0",
                         bus.busy, bus.pixel_valid, bus.frame_done);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic drive(input bit vs, input bit hr, input logic [7:0] d);
        @(negedge clk_in);
        bus.cam_vsync = vs;
        bus.cam_href  = hr;
        bus.cam_data  = d;
    endtask

    // A contiguous HREF run closes: odd length or wrong pixel count is an error.
    task automatic end_seg(input int seg_len, input int seg_px);
        if (m_armed && seg_len > 0 && ((seg_len % 2) != 0 || seg_px != H)) m_err = 1'b1;
    endtask

    // Drive one line; gap_at>0 inserts a one-cycle HREF drop before that byte.
    task automatic send_line(input logic [7:0] b[$], input int gap_at, input bit rand_en);
        int seg_len = 0;
        int seg_px  = 0;
        for (int i = 0; i < b.size(); i++) begin
            if (i == gap_at) begin
                end_seg(seg_len, seg_px);
                drive(1'b0, 1'b0, 8'h00);
                seg_len = 0;
                seg_px  = 0;
            end
            drive(1'b0, 1'b1, b[i]);
            if (rand_en) bus.capture_en = 1'($urandom_range(0, 1));
            seg_len++;
            if ((seg_len % 2) == 0 && m_armed && m_addr < TOT) begin
                pix_q.push_back('{data: {b[i-1], b[i]}, addr: AW'(m_addr), stamp: cyc + 1});
                m_addr++;
                seg_px++;
            end
        end
        end_seg(seg_len, seg_px);
        repeat (2) drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic frame_begin(input bit en);
        @(negedge clk_in);
        bus.cam_vsync  = 1'b0;
        bus.cam_href   = 1'b0;
        bus.capture_en = en;
        m_armed = en;
        m_addr  = 0;
        repeat (2) drive(1'b0, 1'b0, 8'h00);
        chk("busy_after_vs_fall", 32'(bus.busy), 32'(en));
    endtask

    task automatic frame_end();
        drive(1'b1, 1'b0, 8'h00);
        if (m_armed) begin
            fd_q.push_back(cyc + 1);
            m_frames++;
        end
        m_armed = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        chk("busy_after_vs_rise", 32'(bus.busy), 32'd0);
`ifdef OV2640_CAPTURE_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), 32'(m_frames[15:0]));
        chk("line_err", 32'(line_err), 32'(m_err));
`endif
    endtask

    task automatic make_seq(input logic [7:0] start, input int n);
        line_b = {};
        for (int i = 0; i < n; i++) line_b.push_back(start + 8'(i));
    endtask

    task automatic make_rand(input int n);
        line_b = {};
        for (int i = 0; i < n; i++) line_b.push_back(8'($urandom));
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_pixel_out"}, 32'(bus.pixel_out), 32'd0);
        chk({tag, "_pixel_valid"}, 32'(bus.pixel_valid), 32'd0);
        chk({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'd0);
        chk({tag, "_frame_done"}, 32'(bus.frame_done), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
`ifdef OV2640_CAPTURE_STATS_EN
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_line_err"}, 32'(line_err), 32'd0);
`endif
    endtask

    initial begin
        bus.capture_en = 1'b0;
        bus.cam_vsync  = 1'b1;
        bus.cam_href   = 1'b0;
        bus.cam_data   = 8'h00;
        repeat (3) @(negedge clk_in);
        check_zero_outputs("reset");
        rst = 1'b0;
        repeat (3) drive(1'b1, 1'b0, 8'h00);

        // Basic frame: two full lines 0x10..0x1F.
        frame_begin(1'b1);
        make_seq(8'h10, 8); send_line(line_b, -1, 1'b0);
        make_seq(8'h18, 8); send_line(line_b, -1, 1'b0);
        frame_end();

        // Disarmed frame: nothing may come out.
        expect_idle = 1'b1;
        frame_begin(1'b0);
        make_rand(8); send_line(line_b, -1, 1'b0);
        make_rand(8); send_line(line_b, -1, 1'b0);
        frame_end();
        expect_idle = 1'b0;

        // Odd 7-byte line, then a normal line starting at phase 0.
        frame_begin(1'b1);
        make_seq(8'hA0, 7); send_line(line_b, -1, 1'b0);
        make_rand(8); send_line(line_b, -1, 1'b0);
        frame_end();

        // Three lines into a two-line frame: stops at the last address.
        frame_begin(1'b1);
        for (int l = 0; l < 3; l++) begin
            make_seq(8'(8'h40 + 8 * l), 8); send_line(line_b, -1, 1'b0);
        end
        chk("overflow_addr_hold", 32'(bus.wr_addr), 32'(TOT - 1));
        frame_end();

        // Reset in the middle of pixel 3 of the first line.
        frame_begin(1'b1);
        make_seq(8'h60, 7);
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, line_b[i]);
            if ((i % 2) == 1) begin
                pix_q.push_back('{data: {line_b[i-1], line_b[i]}, addr: AW'(m_addr), stamp: cyc + 1});
                m_addr++;
            end
        end
        @(negedge clk_in);
        rst = 1'b1;
        bus.cam_href = 1'b0;
        m_armed  = 1'b0;
        m_frames = 0;
        m_err    = 1'b0;
        @(negedge clk_in);
        check_zero_outputs("midframe_reset");
        rst = 1'b0;
        make_rand(8); send_line(line_b, -1, 1'b0);
        frame_end();
        frame_begin(1'b1);
        make_seq(8'h70, 8); send_line(line_b, -1, 1'b0);
        make_seq(8'h78, 8); send_line(line_b, -1, 1'b0);
        frame_end();

        // HREF drop between the two bytes of a pixel.
        frame_begin(1'b1);
        make_seq(8'hC0, 8); send_line(line_b, 3, 1'b0);
        make_seq(8'hD0, 8); send_line(line_b, -1, 1'b0);
        frame_end();

        // Randomised frames, capture_en toggling mid-frame.
        for (int f = 0; f < 8; f++) begin
            bit en;
            int nl;
            en = ($urandom_range(0, 3) != 0);
            nl = $urandom_range(1, 3);
            expect_idle = !en;
            frame_begin(en);
            for (int l = 0; l < nl; l++) begin
                int len;
                int gap;
                len = $urandom_range(1, 10);
                gap = (len > 1 && $urandom_range(0, 2) == 0) ? $urandom_range(1, len - 1) : -1;
                make_rand(len);
                send_line(line_b, gap, 1'b1);
            end
            frame_end();
            expect_idle = 1'b0;
        end

        repeat (5) @(negedge clk_in);
        chk("pixel_queue_empty", 32'(pix_q.size()), 32'd0);
        chk("frame_done_queue_empty", 32'(fd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard against a stalled run.
    initial begin
        #200000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ov2640_capture.md
Name: ov2640_capture

Overview:
- Upstream stage of the pixel path. Converts the OV2640 8-bit DVP byte stream (VSYNC/HREF/D[7:0]) into 16-bit RGB565 pixels with a linear write address.
- Feeds the frame buffer that supplies the raw and filtered pixel sources to the output selector.
- Captures whole frames only. A frame is armed at a frame boundary when capture_en is high.

Parameters:
- H_RES, 320, active pixels per line.
- V_RES, 240, active lines per frame.
- ADDR_W, 17, wr_addr width. Must satisfy 2^ADDR_W >= H_RES*V_RES.

Ports:
- clk_in  input  1  camera PCLK. Single clock for the whole block. Cam inputs are sampled on the rising edge.
- rst  input  1  synchronous, active-high reset.
- capture_en  input  1  arms capture. Sampled only at the VSYNC falling edge.
- cam_vsync  input  1  frame sync, active high (high = vertical blanking).
- cam_href  input  1  line valid, active high.
- cam_data  input  8  camera byte.
- pixel_out  output  16  RGB565 pixel, {first byte, second byte}.
- pixel_valid  output  1  one-cycle strobe; pixel_out and wr_addr are valid.
- wr_addr  output  ADDR_W  linear address of pixel_out, 0 .. H_RES*V_RES-1.
- frame_done  output  1  one-cycle pulse at the end of a captured frame.
- busy  output  1  high while in state CAPTURE.

Behaviour:
- Reset: all outputs 0; state IDLE; byte phase 0; address counter 0; vsync_d (registered cam_vsync) 0.
- Edge detection:
  - vs_fall = vsync_d & ~cam_vsync.
  - vs_rise = ~vsync_d & cam_vsync.
  - hr_fall = href_d & ~cam_href.
- FSM:
  - IDLE -> WAIT on the first clock after reset.
  - WAIT -> CAPTURE on vs_fall with capture_en=1. At the transition: address counter := 0, byte phase := 0. With capture_en=0 the block stays in WAIT.
  - CAPTURE -> WAIT on vs_rise; frame_done=1 in the following cycle.
- Byte assembly (CAPTURE only, cam_href=1):
  - Phase 0: latch cam_data into hi_byte; phase := 1.
  - Phase 1: pixel_out := {hi_byte, cam_data}; wr_addr := addr_cnt; pixel_valid := 1 in the next cycle; addr_cnt := addr_cnt+1; phase := 0.
  - Latency: 1 clock from sampling the second byte to pixel_valid.
- HREF low: bytes are ignored. On hr_fall the phase resets to 0 and any odd trailing byte is discarded without a strobe.
- Overflow: when addr_cnt = H_RES*V_RES, further pixels produce no strobe and addr_cnt holds. No wrap.
- capture_en deasserted mid-frame: no effect. The current frame completes; no new frame is armed.
- vs_rise and a pixel completion in the same cycle: the pixel is emitted, then the state goes to WAIT.
- rst asserted mid-frame: immediate return to reset values next edge; no frame_done pulse.
- pixel_out holds its last value between strobes.
- Outputs are registered; there are no combinational paths from cam_* to outputs.

Optional Feature:
- Macro: OV2640_CAPTURE_STATS_EN.
- When defined, two extra outputs are added:
  - frame_cnt [15:0]: increments with each frame_done; wraps 0xFFFF -> 0.
  - line_err [0:0], sticky: set on any hr_fall in CAPTURE where the pixels emitted on that line != H_RES, or on an odd byte discard.
  - Both are cleared only by rst.
- When undefined, these ports and their logic are absent. Base behaviour is identical in both builds.

Test Plan:
- Bench uses H_RES=4, V_RES=2. capture_en=1; VSYNC pulse then 2 lines of 8 bytes 0x10..0x1F -> 8 strobes with pixel_out 0x1011, 0x1213 .. 0x1E1F at wr_addr 0..7; frame_done is 1 cycle after the next vs_rise.
- capture_en=0 at vs_fall, full frame driven -> no pixel_valid, no frame_done, busy=0 throughout.
- Line of 7 bytes (0xA0..0xA6) -> 3 strobes (0xA0A1, 0xA2A3, 0xA4A5); 0xA6 dropped; next line starts at phase 0. With the stats macro defined, line_err=1.
- Frame of 3 lines (12 pixels) at V_RES=2 -> strobes stop after wr_addr=7; addr holds; frame_done still pulses.
- rst=1 for 1 cycle mid-line at pixel 3 -> outputs 0 next edge; block re-arms and restarts at wr_addr 0 on the following vs_fall.
- HREF gap mid-line between byte 1 and byte 2 of a pixel -> the partial byte is discarded; no strobe with a stale hi_byte.
